// File: rtl/merlin_alu_arbiter_if.sv
// Requester-side handshake bundle for merlin_alu_arbiter.
// Two requesters share one request/response channel set.
interface merlin_alu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [XLEN-1:0] req0_op_left_i;
  logic [XLEN-1:0] req0_op_right_i;
  logic [OPW-1:0]  req0_op_opcode_i;
  logic [XLEN-1:0] req0_cmp_left_i;
  logic [XLEN-1:0] req0_cmp_right_i;
  logic [2:0]      req0_cmp_opcode_i;
  logic [XLEN-1:0] req1_op_left_i;
  logic [XLEN-1:0] req1_op_right_i;
  logic [OPW-1:0]  req1_op_opcode_i;
  logic [XLEN-1:0] req1_cmp_left_i;
  logic [XLEN-1:0] req1_cmp_right_i;
  logic [2:0]      req1_cmp_opcode_i;
  logic [1:0]      rsp_valid_o;
  logic [1:0]      rsp_ready_i;
  logic [XLEN-1:0] rsp_op_result_o;
  logic            rsp_cmp_result_o;

  modport master (
    output req_valid_i,
    output req0_op_left_i, req0_op_right_i,
    output req0_op_opcode_i,
    output req0_cmp_left_i, req0_cmp_right_i,
    output req0_cmp_opcode_i,
    output req1_op_left_i, req1_op_right_i,
    output req1_op_opcode_i,
    output req1_cmp_left_i, req1_cmp_right_i,
    output req1_cmp_opcode_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_op_result_o,
    input  rsp_cmp_result_o
  );

  modport slave (
    input  req_valid_i,
    input  req0_op_left_i, req0_op_right_i,
    input  req0_op_opcode_i,
    input  req0_cmp_left_i, req0_cmp_right_i,
    input  req0_cmp_opcode_i,
    input  req1_op_left_i, req1_op_right_i,
    input  req1_op_opcode_i,
    input  req1_cmp_left_i, req1_cmp_right_i,
    input  req1_cmp_opcode_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_op_result_o,
    output rsp_cmp_result_o
  );
endinterface

// File: rtl/merlin_alu_arbiter.sv
// Two-requester arbiter in front of a single merlin_alu.
// One result outstanding; issue overlaps with result accept.
module merlin_alu_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int XLEN  = 32,
  parameter int OPW   = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  merlin_alu_arbiter_if.slave bus,
  output logic                alu_stage_en_o,
  output logic [XLEN-1:0]     alu_op_left_o,
  output logic [XLEN-1:0]     alu_op_right_o,
  output logic [OPW-1:0]      alu_op_opcode_o,
  output logic [XLEN-1:0]     alu_cmp_left_o,
  output logic [XLEN-1:0]     alu_cmp_right_o,
  output logic [2:0]          alu_cmp_opcode_o,
  input  logic [XLEN-1:0]     alu_op_result_i,
  input  logic                alu_cmp_result_i
);

  logic busy_q, busy_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic can_issue;
  logic grant;
  logic winner;
  logic sel;

  // Pick a winner; issue only when idle or the held result leaves now.
  always_comb begin
    can_issue = !reset_i && !flush_i
              && (!busy_q || bus.rsp_ready_i[owner_q]);
    grant = can_issue && (|bus.req_valid_i);
    case (bus.req_valid_i)
      2'b10:   winner = 1'b1;
      2'b11:   winner = RR_EN ? ~last_q : 1'b0;
      default: winner = 1'b0;
    endcase
    sel = grant & winner;
  end

  // Next state: flush drops, grant replaces, accept retires.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (grant) begin
      busy_d  = 1'b1;
      owner_d = winner;
      last_d  = winner;
    end else if (busy_q && bus.rsp_ready_i[owner_q]) begin
      busy_d = 1'b0;
    end
  end

  // Ownership registers; last=1 lets requester 0 win first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.req_ready_o = {grant & winner, grant & ~winner};
  assign alu_stage_en_o  = grant;

  assign alu_op_left_o    = sel ? bus.req1_op_left_i
                                : bus.req0_op_left_i;
  assign alu_op_right_o   = sel ? bus.req1_op_right_i
                                : bus.req0_op_right_i;
  assign alu_op_opcode_o  = sel ? bus.req1_op_opcode_i
                                : bus.req0_op_opcode_i;
  assign alu_cmp_left_o   = sel ? bus.req1_cmp_left_i
                                : bus.req0_cmp_left_i;
  assign alu_cmp_right_o  = sel ? bus.req1_cmp_right_i
                                : bus.req0_cmp_right_i;
  assign alu_cmp_opcode_o = sel ? bus.req1_cmp_opcode_i
                                : bus.req0_cmp_opcode_i;

  assign bus.rsp_valid_o      = {busy_q & owner_q,
                                 busy_q & ~owner_q};
  assign bus.rsp_op_result_o  = alu_op_result_i;
  assign bus.rsp_cmp_result_o = alu_cmp_result_i;

endmodule

// File: tb/tb_merlin_alu_arbiter.sv
// Directed bench for merlin_alu_arbiter with ALU models.
// Scoreboard holds results expected from granted requests.
module tb_merlin_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [2:0] C_EQ  = 3'd0;
  localparam logic [2:0] C_NE  = 3'd1;
  localparam logic [2:0] C_LT  = 3'd4;
  localparam logic [2:0] C_GE  = 3'd5;
  localparam logic [2:0] C_LTU = 3'd6;
  localparam logic [2:0] C_GEU = 3'd7;

  typedef struct packed {
    logic [31:0] res;
    logic        cmp;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i;
  logic flush_i;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  merlin_alu_arbiter_if #(.XLEN(32), .OPW(4)) bif0 ();
  merlin_alu_arbiter_if #(.XLEN(32), .OPW(4)) bif1 ();

  logic        a0_en, a1_en;
  logic [31:0] a0_ol, a0_or, a0_cl, a0_cr, a0_res;
  logic [31:0] a1_ol, a1_or, a1_cl, a1_cr, a1_res;
  logic [3:0]  a0_oo, a1_oo;
  logic [2:0]  a0_co, a1_co;
  logic        a0_cmp, a1_cmp;

  always #5 clk = ~clk;

  function automatic logic [31:0] f_op(
    input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic f_cmp(
    input logic [2:0] c, input logic [31:0] a, b);
    case (c)
      C_EQ:    return a == b;
      C_NE:    return a != b;
      C_LT:    return $signed(a) < $signed(b);
      C_GE:    return $signed(a) >= $signed(b);
      C_LTU:   return a < b;
      C_GEU:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (a0_en) begin
      a0_res <= f_op(a0_oo, a0_ol, a0_or);
      a0_cmp <= f_cmp(a0_co, a0_cl, a0_cr);
    end
    if (a1_en) begin
      a1_res <= f_op(a1_oo, a1_ol, a1_or);
      a1_cmp <= f_cmp(a1_co, a1_cl, a1_cr);
    end
  end

  merlin_alu_arbiter #(.RR_EN(1'b1), .XLEN(32), .OPW(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .bus              (bif0),
    .alu_stage_en_o   (a0_en),
    .alu_op_left_o    (a0_ol),
    .alu_op_right_o   (a0_or),
    .alu_op_opcode_o  (a0_oo),
    .alu_cmp_left_o   (a0_cl),
    .alu_cmp_right_o  (a0_cr),
    .alu_cmp_opcode_o (a0_co),
    .alu_op_result_i  (a0_res),
    .alu_cmp_result_i (a0_cmp)
  );

  merlin_alu_arbiter #(.RR_EN(1'b0), .XLEN(32), .OPW(4)) dut_fp (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .bus              (bif1),
    .alu_stage_en_o   (a1_en),
    .alu_op_left_o    (a1_ol),
    .alu_op_right_o   (a1_or),
    .alu_op_opcode_o  (a1_oo),
    .alu_cmp_left_o   (a1_cl),
    .alu_cmp_right_o  (a1_cr),
    .alu_cmp_opcode_o (a1_co),
    .alu_op_result_i  (a1_res),
    .alu_cmp_result_i (a1_cmp)
  );

  assign bif1.req_valid_i       = bif0.req_valid_i;
  assign bif1.rsp_ready_i       = bif0.rsp_ready_i;
  assign bif1.req0_op_left_i    = bif0.req0_op_left_i;
  assign bif1.req0_op_right_i   = bif0.req0_op_right_i;
  assign bif1.req0_op_opcode_i  = bif0.req0_op_opcode_i;
  assign bif1.req0_cmp_left_i   = bif0.req0_cmp_left_i;
  assign bif1.req0_cmp_right_i  = bif0.req0_cmp_right_i;
  assign bif1.req0_cmp_opcode_i = bif0.req0_cmp_opcode_i;
  assign bif1.req1_op_left_i    = bif0.req1_op_left_i;
  assign bif1.req1_op_right_i   = bif0.req1_op_right_i;
  assign bif1.req1_op_opcode_i  = bif0.req1_op_opcode_i;
  assign bif1.req1_cmp_left_i   = bif0.req1_cmp_left_i;
  assign bif1.req1_cmp_right_i  = bif0.req1_cmp_right_i;
  assign bif1.req1_cmp_opcode_i = bif0.req1_cmp_opcode_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic set_req(input int n,
                         input logic [3:0] op,
                         input logic [31:0] a, b,
                         input logic [2:0] c,
                         input logic [31:0] ca, cb);
    if (n == 0) begin
      bif0.req0_op_opcode_i  = op;
      bif0.req0_op_left_i    = a;
      bif0.req0_op_right_i   = b;
      bif0.req0_cmp_opcode_i = c;
      bif0.req0_cmp_left_i   = ca;
      bif0.req0_cmp_right_i  = cb;
    end else begin
      bif0.req1_op_opcode_i  = op;
      bif0.req1_op_left_i    = a;
      bif0.req1_op_right_i   = b;
      bif0.req1_cmp_opcode_i = c;
      bif0.req1_cmp_left_i   = ca;
      bif0.req1_cmp_right_i  = cb;
    end
  endtask

  // Check one cycle of the round-robin DUT, update scoreboard,
  // then advance to 1 time unit after the next rising edge.
  task automatic tick(input logic [1:0] er,
                      input logic [1:0] ev,
                      input string tag);
    exp_t e;
    #3;
    chk({tag, "/req_ready"}, 32'(bif0.req_ready_o), 32'(er));
    chk({tag, "/rsp_valid"}, 32'(bif0.rsp_valid_o), 32'(ev));
    chk({tag, "/stage_en"}, 32'(a0_en), 32'(|er));
    if (ev != 2'b00) begin
      chk({tag, "/sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk({tag, "/op_res"}, bif0.rsp_op_result_o, e.res);
        chk({tag, "/cmp_res"}, 32'(bif0.rsp_cmp_result_o),
            32'(e.cmp));
        if (flush_i || reset_i || bif0.rsp_ready_i[ev[1]])
          void'(sb.pop_front());
      end
    end
    if (er != 2'b00 && !flush_i && !reset_i) begin
      if (er[1]) begin
        e.res = f_op(bif0.req1_op_opcode_i,
                     bif0.req1_op_left_i, bif0.req1_op_right_i);
        e.cmp = f_cmp(bif0.req1_cmp_opcode_i,
                      bif0.req1_cmp_left_i, bif0.req1_cmp_right_i);
      end else begin
        e.res = f_op(bif0.req0_op_opcode_i,
                     bif0.req0_op_left_i, bif0.req0_op_right_i);
        e.cmp = f_cmp(bif0.req0_cmp_opcode_i,
                      bif0.req0_cmp_left_i, bif0.req0_cmp_right_i);
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] er;
    logic [1:0] ev;
    reset_i = 1'b1;
    flush_i = 1'b0;
    bif0.req_valid_i = 2'b00;
    bif0.rsp_ready_i = 2'b00;
    set_req(0, OP_ADD, 0, 0, C_EQ, 0, 0);
    set_req(1, OP_ADD, 0, 0, C_EQ, 0, 0);
    @(posedge clk);
    #1;
    tick(2'b00, 2'b00, "reset");

    // Requester 0 ADD 5 + 7
    reset_i = 1'b0;
    bif0.rsp_ready_i = 2'b11;
    set_req(0, OP_ADD, 5, 7, C_EQ, 5, 7);
    bif0.req_valid_i = 2'b01;
    tick(2'b01, 2'b00, "add_req");
    chk("add_value", bif0.rsp_op_result_o, 32'd12);
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b01, "add_rsp");
    tick(2'b00, 2'b00, "idle");

    // Requester 1 signed and unsigned compares
    set_req(1, OP_ADD, 1, 1, C_LT, 32'hFFFF_FFFF, 1);
    bif0.req_valid_i = 2'b10;
    tick(2'b10, 2'b00, "lt_req");
    chk("lt_value", 32'(bif0.rsp_cmp_result_o), 32'd1);
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b10, "lt_rsp");
    set_req(1, OP_ADD, 1, 1, C_LTU, 32'hFFFF_FFFF, 1);
    bif0.req_valid_i = 2'b10;
    tick(2'b10, 2'b00, "ltu_req");
    chk("ltu_value", 32'(bif0.rsp_cmp_result_o), 32'd0);
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b10, "ltu_rsp");

    // Contention: round-robin vs fixed priority
    set_req(0, OP_ADD, 100, 1, C_EQ, 3, 3);
    set_req(1, OP_SUB, 50, 8, C_GE, 2, 9);
    bif0.req_valid_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      er = (i % 2 == 1) ? 2'b10 : 2'b01;
      ev = (i == 0) ? 2'b00
         : ((i % 2 == 1) ? 2'b01 : 2'b10);
      #2;
      chk("fp_ready", 32'(bif1.req_ready_o), 32'd1);
      chk("fp_valid", 32'(bif1.rsp_valid_o),
          (i == 0) ? 32'd0 : 32'd1);
      tick(er, ev, "rr");
    end
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b10, "rr_tail");

    // Back-pressure on requester 0's SUB result
    set_req(0, OP_SUB, 10, 3, C_NE, 1, 2);
    bif0.req_valid_i = 2'b01;
    tick(2'b01, 2'b00, "sub_req");
    chk("sub_value", bif0.rsp_op_result_o, 32'd7);
    set_req(0, OP_ADD, 1, 1, C_EQ, 0, 0);
    set_req(1, OP_XOR, 32'hF0, 32'h0F, C_GEU, 5, 4);
    bif0.req_valid_i = 2'b11;
    bif0.rsp_ready_i = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick(2'b00, 2'b01, "bp_hold");
      chk("bp_value", bif0.rsp_op_result_o, 32'd7);
    end
    bif0.rsp_ready_i = 2'b11;
    tick(2'b10, 2'b01, "bp_accept");
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b10, "bp_r1");

    // Flush while a result is held
    set_req(0, OP_ADD, 20, 22, C_EQ, 1, 1);
    bif0.req_valid_i = 2'b01;
    tick(2'b01, 2'b00, "fl_req");
    bif0.req_valid_i = 2'b00;
    bif0.rsp_ready_i = 2'b00;
    tick(2'b00, 2'b01, "fl_hold");
    flush_i = 1'b1;
    set_req(0, OP_SUB, 9, 4, C_LTU, 1, 2);
    bif0.req_valid_i = 2'b01;
    tick(2'b00, 2'b01, "fl_pulse");
    flush_i = 1'b0;
    tick(2'b01, 2'b00, "fl_resume");
    bif0.rsp_ready_i = 2'b11;
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b01, "fl_rsp");

    // Reset while a result is held
    set_req(0, OP_ADD, 1, 2, C_EQ, 0, 1);
    bif0.req_valid_i = 2'b01;
    tick(2'b01, 2'b00, "rs_req");
    bif0.req_valid_i = 2'b00;
    bif0.rsp_ready_i = 2'b00;
    tick(2'b00, 2'b01, "rs_hold");
    reset_i = 1'b1;
    tick(2'b00, 2'b01, "rs_reset");
    reset_i = 1'b0;
    bif0.rsp_ready_i = 2'b11;
    set_req(1, OP_ADD, 7, 7, C_EQ, 0, 0);
    bif0.req_valid_i = 2'b11;
    tick(2'b01, 2'b00, "rs_first");
    bif0.req_valid_i = 2'b00;
    tick(2'b00, 2'b01, "rs_rsp");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/merlin_alu_arbiter.md
# merlin_alu_arbiter

Shares one `merlin_alu` instance between two requesters, e.g. the main execute path (requester 0) and a CSR/debug path (requester 1), using valid/ready handshakes. It owns the ALU's `stage_en_i`, steers the winning requester's operands onto the ALU, and routes the registered op and compare results back to that requester. At most one result is outstanding. A new operation may issue in the same cycle the outstanding result is accepted, giving one operation per cycle when responses are not back-pressured.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
- `clk_i` in 1: clock; all state updates on its rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: discard the outstanding result; blocks grants in the same cycle.
- `req_valid_i` in 2: per-requester request valid; bit n = requester n.
- `req_ready_o` out 2: per-requester grant; a transfer occurs when valid & ready.
- `req0_op_left_i`, `req0_op_right_i`, `req1_*` in `RV_XLEN` each: op operands.
- `req0_op_opcode_i`, `req1_op_opcode_i` in `RV_ALUOP_RANGE`: ALU op.
- `req0_cmp_left_i`, `req0_cmp_right_i`, `req1_*` in `RV_XLEN` each: compare operands.
- `req0_cmp_opcode_i`, `req1_cmp_opcode_i` in 3: `RV_ALUCOND_*` code.
- `rsp_valid_o` out 2: per-requester result valid.
- `rsp_ready_i` in 2: per-requester result accept.
- `rsp_op_result_o` out `RV_XLEN`: shared result bus, meaningful for the requester whose `rsp_valid_o` bit is set.
- `rsp_cmp_result_o` out 1: shared compare result.
- `alu_stage_en_o` out 1: to ALU `stage_en_i`.
- `alu_op_left_o`, `alu_op_right_o`, `alu_op_opcode_o`, `alu_cmp_left_o`, `alu_cmp_right_o`, `alu_cmp_opcode_o` out: to the matching ALU inputs.
- `alu_op_result_i` in `RV_XLEN`, `alu_cmp_result_i` in 1: from the ALU.

## Operation
- State: `busy` (result outstanding), `owner` (1 bit, requester of the outstanding result), `last` (1 bit, last granted requester).
- `can_issue = !flush_i && (!busy || rsp_ready_i[owner])`.
- Winner, evaluated only when `can_issue`:
  - Single valid requester: that requester wins.
  - Both valid, `RR_EN=1`: `~last` wins.
  - Both valid, `RR_EN=0`: requester 0 wins.
- `req_ready_o[winner]=1` and `alu_stage_en_o=1`, combinationally, in the grant cycle. Otherwise both are 0.
- Operand mux selects the winner. With no grant it selects requester 0 (don't care, because `stage_en` is low).
- Grant edge: `busy<=1`, `owner<=winner`, `last<=winner`.
- Accept without a new grant: `busy<=0`.
- `rsp_valid_o = busy ? (1<<owner) : 0`. `rsp_*_result_o` are wired directly from the ALU outputs.
- The ALU register updates only on `stage_en`, so result data stays stable while back-pressured. The arbiter holds no result copy.
- `flush_i`: `busy<=0` at the edge. No grant that cycle. Any handshake on `rsp_ready_i` that cycle is ignored.
- Requesters must hold operands stable while valid & !ready. The arbiter does not check this.
- Reset: `busy=0`, `owner=0`, `last=1` (requester 0 wins the first contention).

## Timing
- Reset values: `rsp_valid_o=2'b00`, `req_ready_o=2'b00` (combinational, forced by `busy=0` and the masked inputs), `alu_stage_en_o=0` unless a request is valid in the first cycle after reset.
- Latency: request accepted at edge T, `rsp_valid_o` high in cycle T+1.
- Throughput: 1 op/cycle with `rsp_ready_i` held high. With round-robin contention, grants alternate 0,1,0,1.
- Simultaneous events:
  - Accept of `owner`'s result plus a new grant in the same cycle: `busy` stays 1 and `owner` takes the new winner. This is legal even if the new winner equals the old owner.
  - Back-pressure (`busy` and `!rsp_ready_i[owner]`): no grants, `stage_en=0`, response held indefinitely.
  - `reset_i` mid-operation: outstanding result is dropped, and `rsp_valid_o=0` from the next cycle.

## Test plan
- Req0 ADD, 5 + 7, `rsp_ready`=1: `req_ready_o=01` at T, and `rsp_valid_o=01` with `rsp_op_result_o=12` at T+1.
- Req1 compare LT, -1 vs 1: `rsp_valid_o=10` and `rsp_cmp_result_o=1` at T+1. LTU on the same operands gives 0.
- Both valid for 6 cycles, rsp_ready=11, `RR_EN=1`: grant order is 0,1,0,1,0,1 and each `rsp_valid_o` pulses one cycle later. With `RR_EN=0` the order is 0,0,0,0,0,0.
- Req0 SUB 10-3, then `rsp_ready_i[0]=0` for 3 cycles while both requesters are valid: `rsp_valid_o=01` and result=7 held stable, `req_ready_o=00`, `stage_en=0`. The next grant is req1, in the accept cycle.
- `flush_i` pulse while `busy` with `rsp_ready_i=00`: `rsp_valid_o=00` next cycle, no grant in the flush cycle, and a normal grant resumes the cycle after.
- `reset_i` asserted while a result is held: `rsp_valid_o=00` next cycle. After reset, both valid: requester 0 is granted first.
